// File: rtl/axi_master_read_channel_pkg.sv
// Shared AXI encodings and FSM state type for the cache-refill read master.
// Imported by the read-channel top module.
package axi_master_read_channel_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_master_read_channel.sv
// AXI4 read master: one cache-line refill request becomes one INCR burst.
// R beats are collected into a line buffer and returned with a sticky error flag.
module axi_master_read_channel
  import axi_master_read_channel_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned READ_CHANNEL_WIDTH = 32,
  parameter int unsigned READ_BURST_LEN     = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [ADDR_WIDTH-1:0]                        req_addr,
  output logic                                         resp_valid,
  input  logic                                         resp_ready,
  output logic [READ_CHANNEL_WIDTH*READ_BURST_LEN-1:0] resp_data,
  output logic                                         resp_err,
  output logic                                         ARVALID,
  input  logic                                         ARREADY,
  output logic [ADDR_WIDTH-1:0]                        ARADDR,
  output logic [7:0]                                   ARLEN,
  output logic [2:0]                                   ARSIZE,
  output logic [1:0]                                   ARBURST,
  input  logic                                         RVALID,
  input  logic [READ_CHANNEL_WIDTH-1:0]                RDATA,
  input  logic                                         RLAST,
  input  logic [1:0]                                   RRESP,
  output logic                                         RREADY
);

  localparam int unsigned CNT_W      = $clog2(READ_BURST_LEN) + 1;
  localparam int unsigned ALIGN_BITS = $clog2(READ_CHANNEL_WIDTH / 8 * READ_BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_BITS;
  localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(READ_BURST_LEN - 1);

  rd_state_e                                   state_q;
  logic                                        arvalid_q;
  logic                                        rready_q;
  logic                                        resp_valid_q;
  logic                                        err_q;
  logic                                        err_d;
  logic [CNT_W-1:0]                            cnt_q;
  logic [ADDR_WIDTH-1:0]                       araddr_q;
  logic [READ_CHANNEL_WIDTH*READ_BURST_LEN-1:0] line_q;

  logic beat_fire;
  logic beat_last;
  logic beat_err;

  assign beat_fire = RVALID && rready_q;
  assign beat_last = (cnt_q == LAST_CNT);
  // RLAST must coincide exactly with the counted last beat; it never ends the burst.
  assign beat_err  = (RRESP != AXI_RESP_OKAY) || (RLAST != beat_last);
  assign err_d     = err_q | beat_err;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      araddr_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            araddr_q  <= req_addr & ALIGN_MASK;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            arvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (arvalid_q && ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_fire) begin
            err_q <= err_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (beat_last) begin
              rready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the line buffer is reset because resp_data must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (beat_fire) begin
      for (int k = 0; k < int'(READ_BURST_LEN); k++) begin
        if (cnt_q == CNT_W'(k)) begin
          line_q[k*READ_CHANNEL_WIDTH +: READ_CHANNEL_WIDTH] <= RDATA;
        end
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = line_q;
  assign resp_err   = err_q;
  assign ARVALID    = arvalid_q;
  assign ARADDR     = araddr_q;
  assign ARLEN      = 8'(READ_BURST_LEN - 1);
  assign ARSIZE     = 3'($clog2(READ_CHANNEL_WIDTH / 8));
  assign ARBURST    = AXI_BURST_INCR;
  assign RREADY     = rready_q;

endmodule

// File: tb/tb_axi_master_read_channel.sv
// Directed bench for axi_master_read_channel: drives the AXI slave side by hand
// and checks addresses, beat capture, error flag, latency and reset abort.
module tb_axi_master_read_channel;

  localparam int AW  = 32;
  localparam int W   = 32;
  localparam int LEN = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AW-1:0]    req_addr = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [W*LEN-1:0] resp_data;
  logic             resp_err;
  logic             ARVALID;
  logic             ARREADY = 1'b0;
  logic [AW-1:0]    ARADDR;
  logic [7:0]       ARLEN;
  logic [2:0]       ARSIZE;
  logic [1:0]       ARBURST;
  logic             RVALID = 1'b0;
  logic [W-1:0]     RDATA = '0;
  logic             RLAST = 1'b0;
  logic [1:0]       RRESP = 2'b00;
  logic             RREADY;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ar_hs    = 0;

  axi_master_read_channel #(
    .ADDR_WIDTH        (AW),
    .READ_CHANNEL_WIDTH(W),
    .READ_BURST_LEN    (LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .RVALID    (RVALID),
    .RDATA     (RDATA),
    .RLAST     (RLAST),
    .RRESP     (RRESP),
    .RREADY    (RREADY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && ARVALID && ARREADY) ar_hs <= ar_hs + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [W-1:0] data, input logic [1:0] rr, input logic last);
    RVALID = 1'b1;
    RDATA  = data;
    RRESP  = rr;
    RLAST  = last;
    tick();
    RVALID = 1'b0;
    RRESP  = 2'b00;
    RLAST  = 1'b0;
  endtask

  task automatic run_line(input string tag, input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                          input int ar_stall, input bit gaps, input bit early_ready,
                          input int bad_beat, input logic [1:0] bad_resp, input int last_beat,
                          input logic [W-1:0] base, input logic exp_err);
    int t0;
    int hs0;
    logic [1:0] rr;
    check({tag, "_req_ready"}, req_ready, 1'b1);
    t0        = cyc;
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    hs0       = ar_hs;
    check({tag, "_arvalid"}, ARVALID, 1'b1);
    check({tag, "_araddr"}, ARADDR, exp_addr);
    check({tag, "_rready_addr"}, RREADY, 1'b0);
    for (int i = 0; i < ar_stall; i++) begin
      tick();
      check({tag, "_arvalid_stall"}, ARVALID, 1'b1);
      check({tag, "_araddr_stall"}, ARADDR, exp_addr);
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check({tag, "_arvalid_drop"}, ARVALID, 1'b0);
    check({tag, "_rready"}, RREADY, 1'b1);
    check({tag, "_ar_hs"}, ar_hs - hs0, 1);
    if (early_ready) resp_ready = 1'b1;
    for (int k = 0; k < LEN; k++) begin
      if (gaps && k > 0) begin
        tick();
        check({tag, "_rready_gap"}, RREADY, 1'b1);
      end
      rr = (k == bad_beat) ? bad_resp : 2'b00;
      drive_beat(base + W'(k), rr, k == last_beat);
      if (k == last_beat && k != LEN - 1) begin
        check({tag, "_early_rlast_valid"}, resp_valid, 1'b0);
        check({tag, "_early_rlast_rready"}, RREADY, 1'b1);
      end
    end
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_rready_resp"}, RREADY, 1'b0);
    check({tag, "_resp_err"}, resp_err, exp_err);
    check({tag, "_latency"}, cyc - t0, 2 + LEN + ar_stall + (gaps ? LEN - 1 : 0));
    for (int k = 0; k < LEN; k++) begin
      check({tag, "_slot"}, resp_data[k*W +: W], base + W'(k));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_resp_done"}, resp_valid, 1'b0);
    check({tag, "_idle"}, req_ready, 1'b1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_arvalid", ARVALID, 1'b0);
    check("rst_rready", RREADY, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_araddr", ARADDR, 32'h0);
    check("rst_resp_data", resp_data, 256'h0);
    check("rst_req_ready", req_ready, 1'b1);
    check("arlen", ARLEN, 8'd7);
    check("arsize", ARSIZE, 3'd2);
    check("arburst", ARBURST, 2'b01);
    rst_n = 1'b1;
    tick();

    run_line("t1_basic", 32'h1000_0014, 32'h1000_0000, 0, 1'b0, 1'b0, -1, 2'b00, 7, 32'h0, 1'b0);
    run_line("t2_arstall", 32'h2000_003C, 32'h2000_0020, 5, 1'b0, 1'b0, -1, 2'b00, 7, 32'hA5A5_0000, 1'b0);
    run_line("t3_gaps", 32'h0000_FFFF, 32'h0000_FFE0, 0, 1'b1, 1'b1, -1, 2'b00, 7, 32'h3000_0010, 1'b0);
    run_line("t4_slverr", 32'h1234_5678, 32'h1234_5660, 0, 1'b0, 1'b0, 3, 2'b10, 7, 32'hDEAD_0000, 1'b1);
    run_line("t5_rlast", 32'hFFFF_FFFF, 32'hFFFF_FFE0, 0, 1'b0, 1'b0, -1, 2'b00, 5, 32'h5555_0000, 1'b1);
    run_line("t7_exokay", 32'h0000_0020, 32'h0000_0020, 1, 1'b0, 1'b0, 0, 2'b01, 7, 32'h7700_0000, 1'b1);

    // Reset during beat 4: outputs must clear asynchronously and stay clear.
    req_valid = 1'b1;
    req_addr  = 32'h6000_0010;
    tick();
    req_valid = 1'b0;
    ARREADY   = 1'b1;
    tick();
    ARREADY   = 1'b0;
    for (int k = 0; k < 4; k++) drive_beat(32'hCAFE_0000 + W'(k), 2'b00, 1'b0);
    RVALID = 1'b1;
    RDATA  = 32'hCAFE_0004;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_arvalid", ARVALID, 1'b0);
    check("t6_rst_rready", RREADY, 1'b0);
    tick();
    RVALID = 1'b0;
    check("t6_next_arvalid", ARVALID, 1'b0);
    check("t6_next_rready", RREADY, 1'b0);
    check("t6_next_resp_valid", resp_valid, 1'b0);
    check("t6_next_resp_data", resp_data, 256'h0);
    rst_n = 1'b1;
    tick();
    check("t6_req_ready", req_ready, 1'b1);
    check("t6_araddr", ARADDR, 32'h0);

    run_line("t8_recover", 32'h4000_0047, 32'h4000_0040, 0, 1'b0, 1'b0, -1, 2'b00, 7, 32'h0BAD_F00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
